// File: rtl/fft_pts_serializer.sv
// fft_pts_serializer: double-buffered parallel-to-serial converter for FFT frames.
// A whole frame of NUM_WORDS words loads in one cycle. It is then streamed out one word
// per beat, in natural or bit-reversed index order.
// Ports:
//   clk, rst          clock (rising edge) and asynchronous active-high reset
//   par_valid/ready   frame handshake; par_data word i at [i*WIDTH +: WIDTH]
//   bitrev_en         captured with the frame: 1 = bit-reversed output order
//   ser_valid/ready   beat handshake
//   ser_data          current word (0 when idle)
//   ser_index         source index of ser_data
//   ser_last          final beat of the frame
module fft_pts_serializer #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned NUM_WORDS = 32,
    parameter int unsigned IDX_W     = $clog2(NUM_WORDS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       par_valid,
    output logic                       par_ready,
    input  logic [NUM_WORDS*WIDTH-1:0] par_data,
    input  logic                       bitrev_en,
    output logic                       ser_valid,
    input  logic                       ser_ready,
    output logic [WIDTH-1:0]           ser_data,
    output logic [IDX_W-1:0]           ser_index,
    output logic                       ser_last
);

    if (NUM_WORDS < 2 || (NUM_WORDS & (NUM_WORDS - 1)) != 0 || IDX_W != $clog2(NUM_WORDS))
    begin : g_bad_num_words
        $error("fft_pts_serializer: NUM_WORDS must be a power of 2 >= 2 with IDX_W = clog2");
    end

    localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(NUM_WORDS - 1);

    typedef enum logic {S_IDLE, S_STREAM} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             shd_full_q, shd_full_d;
    logic             act_br_q, shd_br_q;
    logic [WIDTH-1:0] act_mem [NUM_WORDS];
    logic [WIDTH-1:0] shd_mem [NUM_WORDS];

    logic             accept, beat, last_beat;
    logic             load_act_par, load_act_shd, load_shd;
    logic [IDX_W-1:0] idx;

    function automatic logic [IDX_W-1:0] bit_rev(input logic [IDX_W-1:0] v);
        logic [IDX_W-1:0] r;
        for (int unsigned b = 0; b < IDX_W; b++) begin
            r[b] = v[IDX_W-1-b];
        end
        return r;
    endfunction

    // Handshakes, output view of the active buffer, and next-state control.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shd_full_d   = shd_full_q;
        load_act_par = 1'b0;
        load_act_shd = 1'b0;
        load_shd     = 1'b0;

        par_ready = !rst && !shd_full_q;
        accept    = par_valid && par_ready;
        beat      = (state_q == S_STREAM) && ser_ready;
        last_beat = beat && (cnt_q == LAST_CNT);

        idx       = act_br_q ? bit_rev(cnt_q) : cnt_q;
        ser_valid = (state_q == S_STREAM);
        ser_index = ser_valid ? idx : '0;
        ser_data  = ser_valid ? act_mem[idx] : '0;
        ser_last  = ser_valid && (cnt_q == LAST_CNT);

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    load_act_par = 1'b1;
                    cnt_d        = '0;
                    state_d      = S_STREAM;
                end
            end
            S_STREAM: begin
                if (last_beat) begin
                    cnt_d = '0;
                    // A waiting shadow frame wins; par_ready is low then, so no conflict.
                    if (shd_full_q) begin
                        load_act_shd = 1'b1;
                        shd_full_d   = 1'b0;
                    end else if (accept) begin
                        load_act_par = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    if (beat) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (accept) begin
                        load_shd   = 1'b1;
                        shd_full_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counter and frame buffers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            shd_full_q <= 1'b0;
            act_br_q   <= 1'b0;
            shd_br_q   <= 1'b0;
            for (int i = 0; i < int'(NUM_WORDS); i++) begin
                act_mem[i] <= '0;
                shd_mem[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shd_full_q <= shd_full_d;
            if (load_act_par) begin
                act_br_q <= bitrev_en;
            end else if (load_act_shd) begin
                act_br_q <= shd_br_q;
            end
            if (load_shd) begin
                shd_br_q <= bitrev_en;
            end
            for (int i = 0; i < int'(NUM_WORDS); i++) begin
                if (load_act_par) begin
                    act_mem[i] <= par_data[i*WIDTH +: WIDTH];
                end else if (load_act_shd) begin
                    act_mem[i] <= shd_mem[i];
                end
                if (load_shd) begin
                    shd_mem[i] <= par_data[i*WIDTH +: WIDTH];
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_pts_serializer.sv
// tb_fft_pts_serializer: self-checking bench for fft_pts_serializer (WIDTH=16, NUM_WORDS=32).
module tb_fft_pts_serializer;

    localparam int unsigned WIDTH     = 16;
    localparam int unsigned NUM_WORDS = 32;
    localparam int unsigned IDX_W     = 5;
    localparam int unsigned FW        = NUM_WORDS * WIDTH;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [IDX_W-1:0] index;
        logic             last;
    } beat_t;

    logic             tb_clk;
    logic             rst;
    logic             par_valid;
    logic             par_ready;
    logic [FW-1:0]    par_data;
    logic             bitrev_en;
    logic             ser_valid;
    logic             ser_ready;
    logic [WIDTH-1:0] ser_data;
    logic [IDX_W-1:0] ser_index;
    logic             ser_last;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    fft_pts_serializer #(.WIDTH(WIDTH), .NUM_WORDS(NUM_WORDS)) dut (
        .clk       (tb_clk),
        .rst       (rst),
        .par_valid (par_valid),
        .par_ready (par_ready),
        .par_data  (par_data),
        .bitrev_en (bitrev_en),
        .ser_valid (ser_valid),
        .ser_ready (ser_ready),
        .ser_data  (ser_data),
        .ser_index (ser_index),
        .ser_last  (ser_last)
    );

    initial begin
        tb_clk = 1'b0;
        forever #5 tb_clk = ~tb_clk;
    end

    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    // Reference bit reversal built by shifting bits out LSB-first.
    function automatic int rev5(input int k);
        int r = 0;
        int v = k;
        repeat (IDX_W) begin
            r = (r << 1) | (v & 1);
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic logic [FW-1:0] make_frame(input int base);
        logic [FW-1:0] f;
        for (int i = 0; i < int'(NUM_WORDS); i++) begin
            f[i*WIDTH +: WIDTH] = WIDTH'(base + i);
        end
        return f;
    endfunction

    function automatic logic [FW-1:0] junk_frame();
        logic [FW-1:0] f;
        for (int i = 0; i < int'(NUM_WORDS); i++) begin
            f[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        end
        return f;
    endfunction

    task automatic push_frame(input int base, input logic br);
        beat_t b;
        int    ix;
        for (int k = 0; k < int'(NUM_WORDS); k++) begin
            ix      = br ? rev5(k) : k;
            b.data  = WIDTH'(base + ix);
            b.index = IDX_W'(ix);
            b.last  = (k == int'(NUM_WORDS) - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; par_valid = 1'b0; par_data = '0; bitrev_en = 1'b0; ser_ready = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({ser_valid, ser_data, ser_index, ser_last, par_ready} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got valid=%b data=%h idx=%0d last=%b pr=%b, want all 0",
                     ser_valid, ser_data, ser_index, ser_last, par_ready);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (par_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_ready: got par_ready=%b, want 1", par_ready);
        end
    endtask

    // One frame, checked beat by beat; bp selects the 1,0,0,1 ser_ready pattern.
    task automatic test_single_frame(input string name, input int base, input logic br,
                                     input logic bp);
        beat_t h;
        int    nb = 0;
        ser_ready = 1'b1;
        par_data  = make_frame(base);
        bitrev_en = br;
        par_valid = 1'b1;
        n_cmp++;
        if (par_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s accept_ready: got par_ready=%b, want 1", name, par_ready);
        end
        push_frame(base, br);
        tick();
        par_valid = 1'b0;
        bitrev_en = ~br;
        par_data  = junk_frame();
        n_cmp++;
        if (ser_valid !== 1'b1) begin
            n_err++;
            $display("FAIL %s latency: got ser_valid=%b, want 1", name, ser_valid);
        end
        for (int cyc = 0; cyc < 400 && exp_q.size() > 0; cyc++) begin
            ser_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            h = exp_q[0];
            n_cmp++;
            if (ser_valid !== 1'b1) begin
                n_err++;
                $display("FAIL %s bubble at beat %0d: got ser_valid=%b, want 1", name, nb, ser_valid);
            end else if ({ser_data, ser_index, ser_last} !== h) begin
                n_err++;
                $display("FAIL %s beat %0d: got data=%h idx=%0d last=%b, want data=%h idx=%0d last=%b",
                         name, nb, ser_data, ser_index, ser_last, h.data, h.index, h.last);
            end
            if (ser_valid === 1'b1 && ser_ready) begin
                void'(exp_q.pop_front());
                nb++;
            end
            tick();
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s timeout: got %0d beats left, want 0", name, exp_q.size());
            exp_q.delete();
        end
        n_cmp++;
        if (ser_valid !== 1'b0 || ser_data !== '0) begin
            n_err++;
            $display("FAIL %s idle_after: got valid=%b data=%h, want valid=0 data=0",
                     name, ser_valid, ser_data);
        end
        ser_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        beat_t h;
        logic  b_pend = 1'b0;
        logic  launch;
        int    nb = 0;
        ser_ready = 1'b1;
        par_data  = make_frame(32'h000);
        bitrev_en = 1'b0;
        par_valid = 1'b1;
        n_cmp++;
        if (par_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b accept_a: got par_ready=%b, want 1", par_ready);
        end
        push_frame(32'h000, 1'b0);
        tick();
        par_valid = 1'b0;
        for (int cyc = 0; cyc < 400 && exp_q.size() > 0; cyc++) begin
            h = exp_q[0];
            n_cmp++;
            if (ser_valid !== 1'b1 || {ser_data, ser_index, ser_last} !== h) begin
                n_err++;
                $display("FAIL b2b beat %0d: got valid=%b data=%h idx=%0d last=%b, want valid=1 data=%h idx=%0d last=%b",
                         nb, ser_valid, ser_data, ser_index, ser_last, h.data, h.index, h.last);
            end
            n_cmp++;
            if (par_ready !== !b_pend) begin
                n_err++;
                $display("FAIL b2b par_ready at beat %0d: got %b, want %b", nb, par_ready, !b_pend);
            end
            launch = (cyc == 1);
            if (launch) begin
                par_valid = 1'b1;
                par_data  = make_frame(32'h100);
                push_frame(32'h100, 1'b0);
            end
            if (ser_valid === 1'b1) begin
                void'(exp_q.pop_front());
                nb++;
            end
            tick();
            if (launch) begin
                par_valid = 1'b0;
                par_data  = junk_frame();
                b_pend    = 1'b1;
            end
            if (nb == int'(NUM_WORDS)) begin
                b_pend = 1'b0;
            end
        end
        n_cmp++;
        if (exp_q.size() != 0 || nb != 2 * int'(NUM_WORDS)) begin
            n_err++;
            $display("FAIL b2b timeout: got %0d beats, want %0d", nb, 2 * NUM_WORDS);
            exp_q.delete();
        end
        n_cmp++;
        if (ser_valid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b idle_after: got ser_valid=%b, want 0", ser_valid);
        end
    endtask

    task automatic test_reset_mid();
        int nb = 0;
        ser_ready = 1'b1;
        par_data  = make_frame(32'h300);
        bitrev_en = 1'b0;
        par_valid = 1'b1;
        tick();
        par_valid = 1'b0;
        for (int cyc = 0; cyc < 100 && nb < 10; cyc++) begin
            if (cyc == 2) begin
                par_valid = 1'b1;
                par_data  = make_frame(32'h400);
            end
            if (ser_valid === 1'b1) nb++;
            tick();
            par_valid = 1'b0;
        end
        n_cmp++;
        if (ser_valid !== 1'b1 || ser_index !== IDX_W'(10) || par_ready !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid pre: got valid=%b idx=%0d pr=%b, want valid=1 idx=10 pr=0",
                     ser_valid, ser_index, par_ready);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({ser_valid, ser_data, ser_index, ser_last, par_ready} !== '0) begin
            n_err++;
            $display("FAIL rst_mid async: got valid=%b data=%h idx=%0d last=%b pr=%b, want all 0",
                     ser_valid, ser_data, ser_index, ser_last, par_ready);
        end
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_cmp++;
        if (par_ready !== 1'b1 || ser_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid release: got pr=%b valid=%b, want pr=1 valid=0", par_ready, ser_valid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        tick();
        test_single_frame("natural", 32'h000, 1'b0, 1'b0);
        test_single_frame("bitrev", 32'h000, 1'b1, 1'b0);
        test_single_frame("backpressure", 32'h040, 1'b0, 1'b1);
        test_single_frame("bitrev_bp", 32'h080, 1'b1, 1'b1);
        test_back_to_back();
        test_reset_mid();
        test_single_frame("after_reset", 32'h200, 1'b0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
